sram_controller: RTL and testbench
==================================

# sram_controller

Multi-cycle controller that sequences the external 16-bit asynchronous SRAM on behalf of the MEM stage. It accepts one 32-bit read or write per request, splits it into two 16-bit SRAM accesses (low half first), and holds `ready` low until the access completes. The pipeline stage registers use `~ready` as their freeze input.

## Interface
Parameters:
- `WAIT_CYCLES`, 5, cycles each 16-bit SRAM access is held; must be ≥ 1.
- `SRAM_BASE`, 1024, byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  read request from the MEM stage; held stable while `ready`=0.
- `mem_write`  in  1  write request; held stable while `ready`=0.
- `address`  in  32  byte address (ALU result).
- `write_data`  in  32  store data (Rm value).
- `read_data`  out  32  registered load data.
- `ready`  out  1  1 = no access in flight or access completing this cycle; 0 = freeze pipeline.
- `sram_addr`  out  18  SRAM halfword address.
- `sram_dq`  inout  16  SRAM data bus; driven only during write phases, otherwise high-Z.
- `sram_we_n`  out  1  SRAM write enable, active low.

## Operation
- States: IDLE, LOW, HIGH, DONE. Wait counter width is ceil(log2(WAIT_CYCLES+1)).
- `offset = address - SRAM_BASE`, modulo 2^32. `sram_addr = {offset[18:2], half}`, with half=0 in LOW and half=1 in HIGH. Out-of-range addresses wrap silently; `address[1:0]` is ignored.
- IDLE: if `mem_read | mem_write`, go to LOW and clear the counter. Otherwise stay in IDLE.
- LOW: hold for WAIT_CYCLES cycles, then go to HIGH and clear the counter.
  - Write: drive `write_data[15:0]`.
  - Read: on the last LOW cycle, capture `sram_dq` into `read_data[15:0]`.
- HIGH: same as LOW using `write_data[31:16]` and `read_data[31:16]`, then go to DONE.
- DONE: one cycle, then go unconditionally to IDLE.
- `ready` is combinational: 1 in DONE; 1 in IDLE when no request is present; 0 in IDLE when a request is present; 0 in LOW and HIGH. `ready` therefore drops in the same cycle a request appears.
- In DONE the pipeline advances. The request seen in the following IDLE cycle is a new access; back-to-back requests are legal.
- `sram_we_n` = 0 throughout LOW and HIGH for writes; 1 otherwise.
- `read_data` changes only on read captures. It holds its value across writes and idle cycles.
- `mem_read` and `mem_write` both high: treated as a write; `read_data` is unchanged.
- Request inputs are sampled continuously but used only in IDLE. Changes during LOW or HIGH are a protocol violation; behaviour is undefined beyond the FSM completing its sequence.

## Timing
- Reset (asynchronous, any state including mid-access): state=IDLE, counter=0, `read_data`=0, `sram_we_n`=1, `sram_dq`=Z, `sram_addr`=0. `ready` then follows the IDLE rule.
- Request first visible in cycle 0 (IDLE): LOW occupies cycles 1..W, HIGH occupies cycles W+1..2W, DONE is cycle 2W+1.
- `ready`=0 for 2W+1 cycles, i.e. cycles 0..2W, where W = WAIT_CYCLES.
- `read_data` full 32-bit value is valid from the edge ending cycle 2W, so it is stable in DONE.
- `sram_addr` changes only on state transitions and is stable for the whole of each W-cycle phase.
- No request: `ready` stays 1 and the FSM remains in IDLE indefinitely.

## Test plan
- Reset, then idle with no requests for 20 cycles → `ready`=1, `sram_we_n`=1, `sram_dq`=Z, `read_data`=0 throughout.
- Write: `address`=1032, `write_data`=0xDEADBEEF, W=5.
  - `ready`=0 for exactly 11 cycles, then 1 for one cycle.
  - `sram_addr`=4 with dq=0xBEEF for 5 cycles, then `sram_addr`=5 with dq=0xDEAD for 5 cycles.
  - `sram_we_n`=0 for exactly 10 cycles.
- Read back from 1032, with the SRAM model returning the stored data → `read_data`=0xDEADBEEF in DONE; `sram_we_n` stays 1; `sram_dq` is never driven.
- Back-to-back: write to 1024 followed immediately in the next IDLE cycle by a read from 1024 → the second access starts with no extra idle cycle; the read returns the written word.
- Both `mem_read` and `mem_write` high, `address`=1028 → a write to `sram_addr` 2 and 3 occurs; `read_data` is unchanged.
- `rst` asserted during HIGH of a write → outputs take reset values asynchronously; after `rst` deasserts, a new read completes normally in 11 busy cycles.

Source files
------------

// File: rtl/sram_controller.sv
// Two-phase 32-bit access sequencer for a 16-bit asynchronous SRAM.
// Each request becomes a low-half then high-half SRAM access; ready stays low until DONE.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 5,
  parameter logic [31:0] SRAM_BASE   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  inout  wire  [15:0] sram_dq,
  output logic        sram_we_n
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             req_s;
  logic             last_s;
  logic             ready_s;
  logic [31:0]      offset_s;
  logic             write_r;
  logic [17:0]      sram_addr_r;
  logic             we_n_r;
  logic             dq_oe_r;
  logic [15:0]      dq_out_r;
  logic [31:0]      read_data_r;

  assign req_s    = mem_read | mem_write;
  assign last_s   = (cnt_r == CNT_LAST);
  assign offset_s = address - SRAM_BASE;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and ready decode
  always_comb begin
    state_s = state_r;
    ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = ~req_s;
        if (req_s) begin
          state_s = LOW;
        end else begin
          state_s = IDLE;
        end
      end
      LOW: begin
        if (last_s) begin
          state_s = HIGH;
        end else begin
          state_s = LOW;
        end
      end
      HIGH: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = HIGH;
        end
      end
      DONE: begin
        ready_s = 1'b1;
        state_s = IDLE;
      end
      default: begin
        ready_s = 1'b1;
        state_s = IDLE;
      end
    endcase
  end

  // Phase wait counter, cleared on every state change
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (state_s != state_r) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == LOW) || (state_r == HIGH)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= {CNT_W{1'b0}};
    end
  end

  // SRAM pins and load data; the request kind is latched at acceptance so the sequence finishes consistently
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_r     <= 1'b0;
      sram_addr_r <= 18'd0;
      we_n_r      <= 1'b1;
      dq_oe_r     <= 1'b0;
      dq_out_r    <= 16'd0;
      read_data_r <= 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            write_r     <= mem_write;
            sram_addr_r <= {offset_s[18:2], 1'b0};
            we_n_r      <= ~mem_write;
            dq_oe_r     <= mem_write;
            dq_out_r    <= write_data[15:0];
          end
        end
        LOW: begin
          if (last_s) begin
            sram_addr_r <= {sram_addr_r[17:1], 1'b1};
            dq_out_r    <= write_data[31:16];
            if (!write_r) begin
              read_data_r[15:0] <= sram_dq;
            end
          end
        end
        HIGH: begin
          if (last_s) begin
            we_n_r  <= 1'b1;
            dq_oe_r <= 1'b0;
            if (!write_r) begin
              read_data_r[31:16] <= sram_dq;
            end
          end
        end
        DONE: begin
          we_n_r  <= 1'b1;
          dq_oe_r <= 1'b0;
        end
        default: begin
          we_n_r  <= 1'b1;
          dq_oe_r <= 1'b0;
        end
      endcase
    end
  end

  assign ready     = ready_s;
  assign sram_addr = sram_addr_r;
  assign sram_we_n = we_n_r;
  assign read_data = read_data_r;
  assign sram_dq   = dq_oe_r ? dq_out_r : 16'bz;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: vector table of 32-bit accesses against a small
// asynchronous SRAM model, plus hand-written reset-during-access sequence.
module tb_sram_controller;

  localparam int W = 5;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  tri1  [15:0] sram_dq;
  logic        sram_we_n;

  logic [15:0] mem [0:255];
  logic        model_en;
  int          n_tests;
  int          n_fail;

  typedef struct {
    logic        rd;
    logic        wr;
    logic        b2b;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [17:0] base;
  } vec_t;

  vec_t vecs [0:5];

  sram_controller #(.WAIT_CYCLES(W), .SRAM_BASE(32'd1024)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .ready(ready), .sram_addr(sram_addr), .sram_dq(sram_dq), .sram_we_n(sram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: writes while we_n is low, drives the bus only when the bench enables it for reads
  assign sram_dq = model_en ? mem[sram_addr[7:0]] : 16'bz;
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[7:0]] <= sram_dq;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n, input logic [31:0] exp_rd);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check("idle_ready", {31'd0, ready}, 32'd1);
      check("idle_we_n", {31'd0, sram_we_n}, 32'd1);
      check("idle_dq_released", {16'd0, sram_dq}, 32'h0000_FFFF);
      check("idle_read_data", read_data, exp_rd);
    end
  endtask

  task automatic run_access(input vec_t v);
    logic [15:0] exp_dq;
    logic        hi;
    mem_read   = v.rd;
    mem_write  = v.wr;
    address    = v.addr;
    write_data = v.wdata;
    model_en   = !v.wr;
    if (v.b2b) begin
      @(posedge clk); #1;
    end else begin
      #1;
    end
    check("ready_cycle0", {31'd0, ready}, 32'd0);
    check("we_n_cycle0", {31'd0, sram_we_n}, 32'd1);
    for (int c = 1; c <= 2 * W; c++) begin
      @(posedge clk); #1;
      hi = (c > W);
      check($sformatf("ready_busy_c%0d", c), {31'd0, ready}, 32'd0);
      check($sformatf("sram_addr_c%0d", c), {14'd0, sram_addr}, {14'd0, v.base + {17'd0, hi}});
      check($sformatf("we_n_c%0d", c), {31'd0, sram_we_n}, {31'd0, !v.wr});
      if (v.wr) begin
        exp_dq = hi ? v.wdata[31:16] : v.wdata[15:0];
        check($sformatf("dq_write_c%0d", c), {16'd0, sram_dq}, {16'd0, exp_dq});
      end
    end
    @(posedge clk); #1;
    check("ready_done", {31'd0, ready}, 32'd1);
    check("we_n_done", {31'd0, sram_we_n}, 32'd1);
    check("read_data_done", read_data, v.exp_rd);
    model_en = 1'b0;
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    model_en   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 16'd0;

    vecs[0] = '{rd:1'b0, wr:1'b1, b2b:1'b0, addr:32'd1032, wdata:32'hDEADBEEF, exp_rd:32'h0000_0000, base:18'd4};
    vecs[1] = '{rd:1'b1, wr:1'b0, b2b:1'b0, addr:32'd1032, wdata:32'h0000_0000, exp_rd:32'hDEADBEEF, base:18'd4};
    vecs[2] = '{rd:1'b0, wr:1'b1, b2b:1'b0, addr:32'd1024, wdata:32'hCAFEF00D, exp_rd:32'hDEADBEEF, base:18'd0};
    vecs[3] = '{rd:1'b1, wr:1'b0, b2b:1'b1, addr:32'd1024, wdata:32'h0000_0000, exp_rd:32'hCAFEF00D, base:18'd0};
    vecs[4] = '{rd:1'b1, wr:1'b1, b2b:1'b0, addr:32'd1028, wdata:32'h0BADC0DE, exp_rd:32'hCAFEF00D, base:18'd2};
    vecs[5] = '{rd:1'b1, wr:1'b0, b2b:1'b0, addr:32'd1028, wdata:32'h0000_0000, exp_rd:32'h0BADC0DE, base:18'd2};

    rst = 1'b1;
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_we_n", {31'd0, sram_we_n}, 32'd1);
    check("reset_addr", {14'd0, sram_addr}, 32'd0);
    check("reset_read_data", read_data, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(20, 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (!vecs[i].b2b && i > 0) idle(2, vecs[i-1].exp_rd);
      run_access(vecs[i]);
    end
    idle(2, 32'h0BADC0DE);

    // Reset during the HIGH phase of a write
    mem_read   = 1'b0;
    mem_write  = 1'b1;
    address    = 32'd1040;
    write_data = 32'h12345678;
    repeat (W + 2) @(posedge clk);
    #3;
    check("pre_reset_high_addr", {14'd0, sram_addr}, 32'd9);
    check("pre_reset_high_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    #1;
    check("async_rst_read_data", read_data, 32'd0);
    check("async_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("async_rst_addr", {14'd0, sram_addr}, 32'd0);
    check("async_rst_dq_released", {16'd0, sram_dq}, 32'h0000_FFFF);
    check("async_rst_ready_req", {31'd0, ready}, 32'd0);
    mem_write = 1'b0;
    #1;
    check("async_rst_ready_noreq", {31'd0, ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    idle(2, 32'd0);
    run_access('{rd:1'b1, wr:1'b0, b2b:1'b0, addr:32'd1032, wdata:32'h0000_0000, exp_rd:32'hDEADBEEF, base:18'd4});
    idle(2, 32'hDEADBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
